memset_engine: RTL
==================

# memset_engine

Parametrised successor to the fixed-width memset FSM. It fills `n` consecutive words of a single-port RAM, starting at base address `m`, with value `c`, using a one-cycle `start`/`finish` handshake. An optional verify mode reads the region back and counts mismatches. It sits between a controller FSM and a `single_port_ram`-style memory: one write or one read per cycle, with 1-cycle read latency.

## Interface
- `ADDR_WIDTH`, 5, memory address width; addresses wrap modulo 2^ADDR_WIDTH.
- `DATA_WIDTH`, 8, memory word width.
- `LEN_WIDTH`, 32, width of `n` and of `err_count`.

- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `m`  in  ADDR_WIDTH  base address; captured when start is accepted.
- `c`  in  DATA_WIDTH  fill value; captured when start is accepted.
- `n`  in  LEN_WIDTH  word count; captured when start is accepted.
- `mode`  in  1  0 = fill only, 1 = fill then verify; captured when start is accepted.
- `busy`  out  1  high from the cycle after acceptance through the DONE cycle.
- `finish`  out  1  one-cycle completion pulse.
- `return_val`  out  ADDR_WIDTH  captured `m`; valid from the finish cycle and held until the next acceptance.
- `err_count`  out  LEN_WIDTH  verify mismatches; cleared on acceptance, saturates at all-ones.
- `mem_address`  out  ADDR_WIDTH  RAM address.
- `mem_write_enable`  out  1  RAM write strobe.
- `mem_in`  out  DATA_WIDTH  RAM write data; always equals the captured `c`.
- `mem_out`  in  DATA_WIDTH  RAM read data, valid 1 cycle after the address is presented with `mem_write_enable`=0.

## Operation
- States:
  - IDLE: `start`=1 goes to FILL, or to DONE if `n`==0.
  - FILL: goes to VERIFY (`mode`=1) or DONE after the last write.
  - VERIFY: goes to DRAIN after the last read request.
  - DRAIN: goes to DONE.
  - DONE: goes to IDLE.
- Acceptance edge: latch `m`, `c`, `n`, `mode`; set index=0 and err_count=0.
- FILL:
  - `mem_write_enable`=1.
  - `mem_address` = (m + index) mod 2^ADDR_WIDTH.
  - index increments each cycle; leave FILL when index reaches n-1.
- VERIFY:
  - index restarts at 0.
  - `mem_write_enable`=0 and the same address sequence is issued, one read per cycle.
  - Each `mem_out` is compared with `c` in the following cycle (VERIFY or DRAIN). A mismatch increments err_count, saturating.
- `n` > 2^ADDR_WIDTH: addresses wrap and the region is written repeatedly. Verify still performs `n` reads.
- DONE: `finish`=1 for exactly one cycle, `return_val` updated to the captured `m`, then IDLE.
- `start` while busy: ignored, with no effect on captured values.
- `start` held high: a new job is accepted on the first IDLE cycle after DONE.
- Outside FILL/VERIFY: `mem_write_enable`=0 and `mem_address`=0.
- Arithmetic: index is LEN_WIDTH wide; the address sum is truncated to ADDR_WIDTH.
- Reset, including mid-operation:
  - On the next edge: state IDLE, finish=0, busy=0, return_val=0, err_count=0, captured c=0, so mem_in=0.
  - `mem_write_enable`=0 from that edge on; no further writes.
  - A partially filled region is left as-is.

## Timing
- Start accepted at edge t, with n ≥ 1:
  - FILL occupies cycles t+1 .. t+n, one write per cycle.
  - Fill-only: `finish` is high in cycle t+n+1.
  - Verify:
    - Reads are issued in cycles t+n+1 .. t+2n.
    - The last compare happens in DRAIN, cycle t+2n+1.
    - `finish` is high in cycle t+2n+2; `err_count` is final in that cycle.
- n=0: `finish` high in cycle t+1, with no memory access in either mode.
- Throughput: minimum accept-to-accept interval is n+2 cycles (fill-only) or 2n+3 cycles (verify).
- The first read in VERIFY directly follows the last write. The RAM must return the written data for that address in the next cycle.

## Test plan
- Fill only, ADDR_WIDTH=5: m=3, c=0xA5, n=4, mode=0.
  - Writes to 3,4,5,6 in cycles t+1..t+4.
  - finish at t+5.
  - return_val=3; RAM[3..6]=0xA5.
- Wrap: m=30, n=4, c=0x3C.
  - Addresses 30,31,0,1.
  - RAM[2] and RAM[29] unchanged.
- Verify with fault: m=0, n=8, c=0xFF, mode=1; bench forces mem_out=0x00 on the 3rd and 6th reads.
  - finish at t+18; err_count=2.
- Clean verify, same job with a correct RAM: err_count=0.
- Zero length: n=0, mode=1.
  - finish at t+1; mem_write_enable never asserted.
- Start while busy and reset mid-operation:
  - Pulse `start` with a new m during FILL: no effect.
  - Assert reset in cycle t+2 of an n=10 job: next cycle mem_write_enable=0, busy=0, finish=0, return_val=0.
  - A following start runs normally.

Source files
------------

// File: rtl/memset_engine.sv
// memset_engine
//   Fills n consecutive words of a single-port RAM, starting at base address m,
//   with value c. If mode=1 it then reads the region back and counts words that
//   differ from c. One memory access per cycle; the RAM has 1-cycle read latency.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               job request, sampled only in IDLE
//   m, c, n, mode       base address, fill value, word count, verify enable
//   busy                high from the cycle after acceptance through DONE
//   finish              one-cycle completion pulse (DONE state)
//   return_val          captured m, updated on entry to DONE
//   err_count           verify mismatches, cleared on acceptance, saturating
//   mem_address         RAM address (0 outside FILL/VERIFY)
//   mem_write_enable    RAM write strobe
//   mem_in              RAM write data (captured c)
//   mem_out             RAM read data, valid one cycle after a read address
module memset_engine #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] m,
  input  logic [DATA_WIDTH-1:0] c,
  input  logic [LEN_WIDTH-1:0]  n,
  input  logic                  mode,
  output logic                  busy,
  output logic                  finish,
  output logic [ADDR_WIDTH-1:0] return_val,
  output logic [LEN_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_in,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_VERIFY,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] m_q;
  logic [DATA_WIDTH-1:0] c_q;
  logic [LEN_WIDTH-1:0]  n_q;
  logic                  mode_q;
  logic [LEN_WIDTH-1:0]  idx_q;
  logic                  cmp_q;     // mem_out this cycle answers a verify read
  logic                  busy_q;
  logic                  finish_q;
  logic [ADDR_WIDTH-1:0] ret_q;
  logic [LEN_WIDTH-1:0]  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;

  logic [LEN_WIDTH-1:0]  idx_inc_d;
  logic                  last_d;
  logic [ADDR_WIDTH-1:0] addr_next_d;
  logic                  mismatch_d;

  always_comb begin
    idx_inc_d   = idx_q + LEN_WIDTH'(1);
    last_d      = (idx_q == n_q - LEN_WIDTH'(1));
    // Address sum is truncated, so regions longer than the memory wrap.
    addr_next_d = m_q + idx_inc_d[ADDR_WIDTH-1:0];
    mismatch_d  = cmp_q && (mem_out != c_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      m_q      <= '0;
      c_q      <= '0;
      n_q      <= '0;
      mode_q   <= 1'b0;
      idx_q    <= '0;
      cmp_q    <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      ret_q    <= '0;
      err_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
    end else begin
      // A read issued in VERIFY returns its data next cycle (VERIFY or DRAIN).
      cmp_q <= (state_q == S_VERIFY);
      if (mismatch_d && (err_q != '1)) begin
        err_q <= err_q + LEN_WIDTH'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            m_q    <= m;
            c_q    <= c;
            n_q    <= n;
            mode_q <= mode;
            idx_q  <= '0;
            err_q  <= '0;
            busy_q <= 1'b1;
            if (n == '0) begin
              state_q  <= S_DONE;
              finish_q <= 1'b1;
              ret_q    <= m;
            end else begin
              state_q <= S_FILL;
              addr_q  <= m;
              we_q    <= 1'b1;
            end
          end
        end

        S_FILL: begin
          if (last_d) begin
            we_q <= 1'b0;
            if (mode_q) begin
              // Read-back starts right behind the last write.
              state_q <= S_VERIFY;
              idx_q   <= '0;
              addr_q  <= m_q;
            end else begin
              state_q  <= S_DONE;
              addr_q   <= '0;
              finish_q <= 1'b1;
              ret_q    <= m_q;
            end
          end else begin
            idx_q  <= idx_inc_d;
            addr_q <= addr_next_d;
          end
        end

        S_VERIFY: begin
          if (last_d) begin
            state_q <= S_DRAIN;
            addr_q  <= '0;
          end else begin
            idx_q  <= idx_inc_d;
            addr_q <= addr_next_d;
          end
        end

        S_DRAIN: begin
          // Last compare happens on this edge via cmp_q.
          state_q  <= S_DONE;
          finish_q <= 1'b1;
          ret_q    <= m_q;
        end

        S_DONE: begin
          state_q  <= S_IDLE;
          finish_q <= 1'b0;
          busy_q   <= 1'b0;
        end

        default: begin
          state_q  <= S_IDLE;
          finish_q <= 1'b0;
          busy_q   <= 1'b0;
          we_q     <= 1'b0;
          addr_q   <= '0;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign finish           = finish_q;
  assign return_val       = ret_q;
  assign err_count        = err_q;
  assign mem_address      = addr_q;
  assign mem_write_enable = we_q;
  assign mem_in           = c_q;

endmodule
